// File: rtl/seg_digit_reader_pkg.sv
// Shared definitions for the seven-segment digit reader: segment patterns,
// FSM state encoding and field widths.
package seg_digit_reader_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;
    localparam int CNT_W   = 4;

    // Active-high segments, bit 6 = g down to bit 0 = a.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        WAIT_BLANK,
        WAIT_DIGIT,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg_digit_reader_decode.sv
// Combinational segment-pattern classifier: legal digit, blank, or neither.
module seg_pattern_decode
    import seg_digit_reader_pkg::*;
(
    input  logic [SEG_W-1:0]   i_seg,
    output logic               o_legal,
    output logic               o_blank,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_legal = 1'b0;
        o_blank = 1'b0;
        o_digit = '0;
        case (i_seg)
            SEG_0:     begin o_legal = 1'b1; o_digit = 4'd0; end
            SEG_1:     begin o_legal = 1'b1; o_digit = 4'd1; end
            SEG_2:     begin o_legal = 1'b1; o_digit = 4'd2; end
            SEG_3:     begin o_legal = 1'b1; o_digit = 4'd3; end
            SEG_4:     begin o_legal = 1'b1; o_digit = 4'd4; end
            SEG_5:     begin o_legal = 1'b1; o_digit = 4'd5; end
            SEG_6:     begin o_legal = 1'b1; o_digit = 4'd6; end
            SEG_7:     begin o_legal = 1'b1; o_digit = 4'd7; end
            SEG_8:     begin o_legal = 1'b1; o_digit = 4'd8; end
            SEG_9:     begin o_legal = 1'b1; o_digit = 4'd9; end
            SEG_BLANK: o_blank = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg_digit_reader.sv
// Debounces a seven-segment input stream and emits each digit once, using a
// return-to-blank protocol so repeated digits are separated by a stable blank.
module seg_digit_reader
    import seg_digit_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEG_W-1:0]   seg,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_valid,
    output logic [9:0]         digit_count,
    output logic               err
);

    localparam logic [CNT_W-1:0] LP_BLANK_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_SETTLE_LAST =
        (STABLE_CYCLES >= 2) ? CNT_W'(STABLE_CYCLES - 2) : '0;
    localparam bit LP_SINGLE = (STABLE_CYCLES == 1);

    logic [SEG_W-1:0]   r_seg;
    logic               r_primed;
    state_t             r_state;
    logic [SEG_W-1:0]   r_cand;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIGIT_W-1:0] r_digit;
    logic               r_valid;
    logic [9:0]         r_count;
    logic               r_err;

    state_t             w_state_nxt;
    logic [SEG_W-1:0]   w_cand_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_legal;
    logic               w_blank;
    logic [DIGIT_W-1:0] w_digit;

    // Whenever a pattern is accepted it equals the current sample, so one
    // decoder on the sample register serves both blank detection and output.
    seg_pattern_decode u_decode (
        .i_seg   (r_seg),
        .o_legal (w_legal),
        .o_blank (w_blank),
        .o_digit (w_digit)
    );

    // r_primed masks the reset value of r_seg so it never counts as a blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= '0;
            r_primed <= 1'b0;
        end else begin
            r_seg    <= seg;
            r_primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_BLANK;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (r_primed) begin
            case (r_state)
                WAIT_BLANK: begin
                    if (w_blank) begin
                        if (r_cnt == LP_BLANK_LAST) begin
                            w_state_nxt = WAIT_DIGIT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                WAIT_DIGIT: begin
                    if (!w_blank) begin
                        w_cand_nxt = r_seg;
                        w_cnt_nxt  = '0;
                        if (LP_SINGLE) begin
                            w_accept    = 1'b1;
                            w_state_nxt = HOLD;
                        end else begin
                            w_state_nxt = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (w_blank) begin
                        w_state_nxt = WAIT_DIGIT;
                        w_cnt_nxt   = '0;
                    end else if (r_seg == r_cand) begin
                        if (r_cnt == LP_SETTLE_LAST) begin
                            w_accept    = 1'b1;
                            w_state_nxt = HOLD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        w_cand_nxt = r_seg;
                        w_cnt_nxt  = '0;
                        if (LP_SINGLE) begin
                            w_accept    = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_blank) begin
                        w_state_nxt = WAIT_BLANK;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_BLANK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // An accepted illegal pattern only raises the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_accept && w_legal;
            if (w_accept && w_legal) begin
                r_digit <= w_digit;
                r_count <= r_count + 1'b1;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_valid;
    assign digit_count = r_count;
    assign err         = r_err;

endmodule

// File: tb/tb_seg_digit_reader.sv
// Self-checking bench for seg_digit_reader: vector table plus scoreboard of
// expected digit pulses, with hand-written reset, wrap and STABLE_CYCLES=1 cases.
module tb_seg_digit_reader;

    typedef struct {
        logic [6:0] pat;
        int         cycles;
        bit         pulse;
    } vec_t;

    typedef struct {
        int dig;
        int cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] digit;
    logic       digit_valid;
    logic [9:0] digit_count;
    logic       err;
    logic [3:0] digit1;
    logic       digit_valid1;
    logic [9:0] digit_count1;
    logic       err1;

    int   total = 0;
    int   bad = 0;
    int   expCount = 0;
    exp_t sbQ[$];
    vec_t tbl[$];
    bit   prevValid = 1'b0;

    localparam logic [6:0] BLK = 7'b0000000;
    localparam logic [6:0] ILL = 7'b1010101;
    logic [6:0] digPat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

    seg_digit_reader #(.STABLE_CYCLES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_count (digit_count),
        .err         (err)
    );

    seg_digit_reader #(.STABLE_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .digit       (digit1),
        .digit_valid (digit_valid1),
        .digit_count (digit_count1),
        .err         (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] pat, input int cycles);
        seg = pat;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pushDigit(input int d);
        expCount = (expCount + 1) % 1024;
        sbQ.push_back('{d, expCount});
    endtask

    task automatic addVec(input logic [6:0] pat, input int cycles, input bit pulse);
        tbl.push_back('{pat, cycles, pulse});
    endtask

    function automatic int patToDigit(input logic [6:0] pat);
        for (int k = 0; k < 10; k++) begin
            if (digPat[k] == pat) return k;
        end
        return -1;
    endfunction

    // Scoreboard monitor for the STABLE_CYCLES=3 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (digit_valid) begin
                checkOutput("valid_not_back_to_back", int'(prevValid), 0);
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: got digit %0d count %0d expected no pulse",
                             digit, digit_count);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("pulse_digit", int'(digit), e.dig);
                    checkOutput("pulse_count", int'(digit_count), e.cnt);
                end
            end
            prevValid = digit_valid;
        end
    end

    initial begin
        int wrapN;
        rst_n = 1'b0;
        seg   = BLK;
        #1;
        checkOutput("reset_digit", int'(digit), 0);
        checkOutput("reset_valid", int'(digit_valid), 0);
        checkOutput("reset_count", int'(digit_count), 0);
        checkOutput("reset_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic digit, digit stream, long hold, glitch, repeated digits.
        addVec(BLK, 3, 0);        addVec(digPat[3], 3, 1);  addVec(BLK, 4, 0);
        addVec(digPat[3], 4, 1);  addVec(BLK, 4, 0);
        addVec(digPat[1], 4, 1);  addVec(BLK, 4, 0);
        addVec(digPat[4], 4, 1);  addVec(BLK, 4, 0);
        addVec(digPat[1], 4, 1);  addVec(BLK, 4, 0);
        addVec(digPat[5], 4, 1);  addVec(BLK, 4, 0);
        addVec(digPat[3], 10, 1); addVec(BLK, 4, 0);
        addVec(digPat[3], 2, 0);  addVec(digPat[5], 2, 0);
        addVec(digPat[3], 3, 1);  addVec(BLK, 4, 0);
        addVec(digPat[3], 4, 1);  addVec(BLK, 1, 0);
        addVec(digPat[3], 4, 0);  addVec(BLK, 4, 0);
        addVec(digPat[3], 4, 1);  addVec(BLK, 4, 0);

        foreach (tbl[i]) begin
            if (tbl[i].pulse) pushDigit(patToDigit(tbl[i].pat));
            applyStimulus(tbl[i].pat, tbl[i].cycles);
        end
        repeat (2) @(negedge clk);
        checkOutput("table_drained", sbQ.size(), 0);
        checkOutput("table_count", int'(digit_count), 10);
        checkOutput("digit_held", int'(digit), 3);
        checkOutput("err_clear", int'(err), 0);

        // Stable illegal pattern: sticky error, no pulse.
        applyStimulus(ILL, 4);
        checkOutput("err_set", int'(err), 1);
        applyStimulus(BLK, 4);
        pushDigit(8);
        applyStimulus(digPat[8], 4);
        applyStimulus(BLK, 4);
        checkOutput("err_sticky", int'(err), 1);
        checkOutput("illegal_drained", sbQ.size(), 0);

        // Count up to the 1024th pulse so the counter wraps to zero.
        wrapN = 1024 - expCount;
        for (int n = 0; n < wrapN; n++) begin
            pushDigit(n % 10);
            applyStimulus(digPat[n % 10], 3);
            applyStimulus(BLK, 4);
        end
        checkOutput("wrap_drained", sbQ.size(), 0);
        checkOutput("wrap_count_zero", int'(digit_count), 0);
        checkOutput("wrap_err_kept", int'(err), 1);

        // Reset asserted mid-SETTLE: immediate clear, candidate discarded.
        applyStimulus(digPat[7], 2);
        #2 rst_n = 1'b0;
        #1;
        expCount = 0;
        checkOutput("midreset_digit", int'(digit), 0);
        checkOutput("midreset_valid", int'(digit_valid), 0);
        checkOutput("midreset_count", int'(digit_count), 0);
        checkOutput("midreset_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(digPat[7], 6);
        checkOutput("no_accept_without_blank", int'(digit_count), 0);
        applyStimulus(BLK, 4);

        // STABLE_CYCLES=1 instance pulses one cycle after its first sample.
        pushDigit(7);
        seg = digPat[7];
        @(negedge clk);
        checkOutput("n1_valid_early", int'(digit_valid1), 0);
        @(negedge clk);
        checkOutput("n1_valid", int'(digit_valid1), 1);
        checkOutput("n1_digit", int'(digit1), 7);
        @(negedge clk);
        checkOutput("n1_valid_drop", int'(digit_valid1), 0);
        applyStimulus(BLK, 4);
        checkOutput("final_drained", sbQ.size(), 0);
        checkOutput("final_count", int'(digit_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
